mips_multicycle_ctrl: RTL and testbench

- Control FSM and ALU decoder that sequences the shared-memory multicycle MIPS datapath; replaces the combinational single-cycle control in top_view's next revision.
- Consumes opcode/funct from the instruction register and ALU zero flag; drives all datapath mux selects, write enables and ALU control.
- Supports lw, sw, R-type (add, sub, and, or, slt), beq, addi, j; waits on a memory-ready handshake.

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/mips_multicycle_ctrl_if.sv | 39 +++
 rtl/mips_aludec.sv | 30 +++
 rtl/mips_multicycle_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS control constants: opcodes, functs, ALU codes, FSM states.
// Used by both the multicycle controller and the single-cycle core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    AOP_ADD = 2'b00,
    AOP_SUB = 2'b01,
    AOP_FN  = 2'b10,
    AOP_RSV = 2'b11
  } aluop_e;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  function automatic logic funct_ok(logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) ||
           (f == FN_AND) || (f == FN_OR) ||
           (f == FN_SLT);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Datapath <-> controller bundle: instruction fields and flags in,
// selects, strobes and debug state out.
interface mips_multicycle_ctrl_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               pcen;
  logic               irwrite;
  logic               memwrite;
  logic               regwrite;
  logic               iord;
  logic               memtoreg;
  logic               regdst;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [1:0]         pcsrc;
  logic [2:0]         alucontrol;
  logic               illegal;
  logic [STATE_W-1:0] state;

  modport master (
    output op, funct, zero, mem_ready,
    input  pcen, irwrite, memwrite, regwrite,
    input  iord, memtoreg, regdst, alusrca,
    input  alusrcb, pcsrc, alucontrol,
    input  illegal, state
  );

  modport slave (
    input  op, funct, zero, mem_ready,
    output pcen, irwrite, memwrite, regwrite,
    output iord, memtoreg, regdst, alusrca,
    output alusrcb, pcsrc, alucontrol,
    output illegal, state
  );
endinterface

// File: rtl/mips_aludec.sv
// ALU decoder: aluop + funct -> 3-bit ALU control.
// Shared with the single-cycle core.
module mips_aludec
  import mips_pkg::*;
(
  input  aluop_e     aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    unique case (aluop_i)
      AOP_ADD: alucontrol_o = ALU_ADD;
      AOP_SUB: alucontrol_o = ALU_SUB;
      AOP_FN: begin
        unique case (1'b1)
          funct_i == FN_ADD: alucontrol_o = ALU_ADD;
          funct_i == FN_SUB: alucontrol_o = ALU_SUB;
          funct_i == FN_AND: alucontrol_o = ALU_AND;
          funct_i == FN_OR:  alucontrol_o = ALU_OR;
          funct_i == FN_SLT: alucontrol_o = ALU_SLT;
          default:           alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences the shared-memory datapath
// for lw/sw/R-type/beq/addi/j with a memory-ready handshake.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int STATE_W     = 4,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic                   clk,
  input logic                   reset,
  mips_multicycle_ctrl_if.slave bus
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [3:0]         cs;
  state_e             nxt;

  logic   mem_rdy;
  logic   is_mem, is_r, is_beq, is_addi, is_j, dec_ok;
  logic   pcwrite, branch;
  logic   irwrite, memwrite, regwrite, iord;
  logic   memtoreg, regdst, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  aluop_e aluop;
  logic [2:0] aluc;

  assign mem_rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  assign is_mem  = (bus.op == OP_LW) || (bus.op == OP_SW);
  assign is_r    = (bus.op == OP_RTYPE) && funct_ok(bus.funct);
  assign is_beq  = (bus.op == OP_BEQ);
  assign is_addi = (bus.op == OP_ADDI);
  assign is_j    = (bus.op == OP_J);
  assign dec_ok  = is_mem | is_r | is_beq | is_addi | is_j;

  // Wide state registers map any high-bit pattern onto an unused code.
  assign cs = ((state_q >> 4) == '0) ? state_q[3:0] : 4'hF;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= '0;
    else        state_q <= state_d;
  end

  always_comb begin
    nxt = S_FETCH;
    case (cs)
      S_FETCH:   nxt = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          is_mem:  nxt = S_MEMADR;
          is_r:    nxt = S_EXECUTE;
          is_beq:  nxt = S_BRANCH;
          is_addi: nxt = S_ADDIEX;
          is_j:    nxt = S_JUMP;
          default: nxt = S_FETCH;
        endcase
      end
      S_MEMADR:  nxt = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   nxt = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:   nxt = mem_rdy ? S_FETCH : S_MEMWR;
      S_EXECUTE: nxt = S_ALUWB;
      S_ADDIEX:  nxt = S_ADDIWB;
      default:   nxt = S_FETCH;
    endcase
    state_d = STATE_W'(nxt);
  end

  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = AOP_ADD;
    illegal  = 1'b0;
    case (cs)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_rdy;
        pcwrite = mem_rdy;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        illegal = ~dec_ok;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = AOP_FN;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = AOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    // Reset silences everything immediately, even mid-access.
    if (!reset) begin
      pcwrite  = 1'b0;
      branch   = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      iord     = 1'b0;
      memtoreg = 1'b0;
      regdst   = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      aluop    = AOP_ADD;
      illegal  = 1'b0;
    end
  end

  mips_aludec u_aludec (
    .aluop_i      (aluop),
    .funct_i      (bus.funct),
    .alucontrol_o (aluc)
  );

  assign bus.pcen       = pcwrite | (branch & bus.zero);
  assign bus.irwrite    = irwrite;
  assign bus.memwrite   = memwrite;
  assign bus.regwrite   = regwrite;
  assign bus.iord       = iord;
  assign bus.memtoreg   = memtoreg;
  assign bus.regdst     = regdst;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = aluc;
  assign bus.illegal    = illegal;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench: per-instruction cycle model vs two controller
// instances (memory wait honoured / ignored).
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluc;
    logic       ill;
  } obs_t;

  typedef struct {
    obs_t o;
    logic mr;
    logic rst;
    bit   chk;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if #(.STATE_W(4)) bus1 ();
  mips_multicycle_ctrl_if #(.STATE_W(4)) bus2 ();

  mips_multicycle_ctrl #(.STATE_W(4), .MEM_WAIT_EN(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  mips_multicycle_ctrl #(.STATE_W(4), .MEM_WAIT_EN(1'b0)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  assign bus2.op        = bus1.op;
  assign bus2.funct     = bus1.funct;
  assign bus2.zero      = bus1.zero;
  assign bus2.mem_ready = 1'b0;

  obs_t got1, got2;
  assign got1 = {bus1.state, bus1.pcen, bus1.irwrite, bus1.memwrite,
                 bus1.regwrite, bus1.iord, bus1.memtoreg, bus1.regdst,
                 bus1.alusrca, bus1.alusrcb, bus1.pcsrc,
                 bus1.alucontrol, bus1.illegal};
  assign got2 = {bus2.state, bus2.pcen, bus2.irwrite, bus2.memwrite,
                 bus2.regwrite, bus2.iord, bus2.memtoreg, bus2.regdst,
                 bus2.alusrca, bus2.alusrcb, bus2.pcsrc,
                 bus2.alucontrol, bus2.illegal};

  int    nvec = 0;
  int    nerr = 0;
  bit    use2 = 1'b0;
  step_t q[$];

  function automatic obs_t base(logic [3:0] st);
    obs_t o = '0;
    o.st   = st;
    o.aluc = 3'b010;
    return o;
  endfunction

  function automatic logic [2:0] alu_of(logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  task automatic add(obs_t o, logic mr, logic rst, bit chk);
    step_t s;
    s.o = o; s.mr = mr; s.rst = rst; s.chk = chk;
    q.push_back(s);
  endtask

  task automatic m_fetch(int stalls);
    obs_t o;
    repeat (stalls) begin
      o = base(0); o.alusrcb = 2'b01;
      add(o, 1'b0, 1'b1, 1'b1);
    end
    o = base(0); o.alusrcb = 2'b01;
    o.irwrite = 1'b1; o.pcen = 1'b1;
    add(o, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic m_decode(logic ill);
    obs_t o = base(1);
    o.alusrcb = 2'b11; o.ill = ill;
    add(o, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic m_memadr();
    obs_t o = base(2);
    o.alusrca = 1'b1; o.alusrcb = 2'b10;
    add(o, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic m_memwr(int stalls);
    obs_t o = base(5);
    o.iord = 1'b1; o.memwrite = 1'b1;
    repeat (stalls) add(o, 1'b0, 1'b1, 1'b1);
    add(o, 1'b1, 1'b1, 1'b1);
  endtask

  // Whole-instruction timeline as seen from the datapath.
  task automatic model(logic [5:0] op, logic [5:0] fn, logic z,
                       int fs, int ms);
    obs_t o;
    bit   rlegal;
    rlegal = (fn == 6'b100000) || (fn == 6'b100010) ||
             (fn == 6'b100100) || (fn == 6'b100101) ||
             (fn == 6'b101010);
    m_fetch(fs);
    if (op == 6'b100011) begin
      m_decode(1'b0); m_memadr();
      o = base(3); o.iord = 1'b1;
      repeat (ms) add(o, 1'b0, 1'b1, 1'b1);
      add(o, 1'b1, 1'b1, 1'b1);
      o = base(4); o.memtoreg = 1'b1; o.regwrite = 1'b1;
      add(o, 1'b0, 1'b1, 1'b1);
    end else if (op == 6'b101011) begin
      m_decode(1'b0); m_memadr(); m_memwr(ms);
    end else if (op == 6'b000000 && rlegal) begin
      m_decode(1'b0);
      o = base(6); o.alusrca = 1'b1; o.aluc = alu_of(fn);
      add(o, 1'b0, 1'b1, 1'b1);
      o = base(7); o.regdst = 1'b1; o.regwrite = 1'b1;
      add(o, 1'b0, 1'b1, 1'b1);
    end else if (op == 6'b000100) begin
      m_decode(1'b0);
      o = base(8); o.alusrca = 1'b1; o.aluc = 3'b110;
      o.pcsrc = 2'b01; o.pcen = z;
      add(o, 1'b0, 1'b1, 1'b1);
    end else if (op == 6'b001000) begin
      m_decode(1'b0);
      o = base(9); o.alusrca = 1'b1; o.alusrcb = 2'b10;
      add(o, 1'b0, 1'b1, 1'b1);
      o = base(10); o.regwrite = 1'b1;
      add(o, 1'b0, 1'b1, 1'b1);
    end else if (op == 6'b000010) begin
      m_decode(1'b0);
      o = base(11); o.pcsrc = 2'b10; o.pcen = 1'b1;
      add(o, 1'b0, 1'b1, 1'b1);
    end else begin
      m_decode(1'b1);
    end
  endtask

  task automatic cmp(string nm, int cyc, int k, obs_t g, step_t s);
    nvec++;
    if (!s.chk) g.st = s.o.st;
    if (g !== s.o) begin
      nerr++;
      $display("FAIL %s cyc%0d dut%0d got %h want %h",
               nm, cyc, k, g, s.o);
    end
  endtask

  task automatic pin(bit ok, string nm);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s model pin not met", nm);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic play(string nm);
    step_t s;
    for (int i = 0; i < q.size(); i++) begin
      s = q[i];
      reset = s.rst;
      bus1.mem_ready = s.mr;
      @(negedge clk);
      cmp(nm, i, 1, got1, s);
      if (use2) cmp(nm, i, 2, got2, s);
      @(posedge clk); #1;
    end
    q.delete();
  endtask

  task automatic run(logic [5:0] op, logic [5:0] fn, logic z,
                     int fs, int ms, int len, string nm);
    bus1.op = op; bus1.funct = fn; bus1.zero = z;
    model(op, fn, z, fs, ms);
    nvec++;
    if (q.size() != len) begin
      nerr++;
      $display("FAIL len_%s got %0d want %0d", nm, q.size(), len);
    end
    play(nm);
  endtask

  logic [5:0] fl [4];

  initial begin
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};
    reset = 1'b0;
    bus1.op = '0; bus1.funct = '0;
    bus1.zero = 1'b0; bus1.mem_ready = 1'b0;
    @(posedge clk); #1;

    add(base(0), 1'b0, 1'b0, 1'b1);
    add(base(0), 1'b1, 1'b0, 1'b1);
    play("rst_init");

    run(6'b100011, 6'h00, 1'b0, 0, 0, 5, "lw");
    run(6'b101011, 6'h00, 1'b0, 0, 2, 6, "sw_wait2");
    run(6'b000100, 6'h00, 1'b1, 0, 0, 3, "beq_taken");
    run(6'b000100, 6'h00, 1'b0, 0, 0, 3, "beq_not");

    model(6'b000000, 6'b101010, 1'b0, 0, 0);
    pin(q[2].o.aluc == 3'b111, "slt_code");
    pin(q[3].o.regwrite && q[3].o.regdst, "aluwb_wr");
    q.delete();
    run(6'b000000, 6'b101010, 1'b0, 0, 0, 4, "slt");
    run(6'b000000, 6'b100111, 1'b0, 0, 0, 2, "rtype_bad");
    run(6'b000010, 6'h00, 1'b0, 0, 0, 3, "j");
    run(6'b111111, 6'h00, 1'b0, 0, 0, 2, "op_bad");
    run(6'b001000, 6'h00, 1'b0, 0, 0, 4, "addi");
    for (int i = 0; i < 4; i++)
      run(6'b000000, fl[i], 1'b1, 0, 0, 4, "rtype");
    run(6'b100011, 6'h00, 1'b0, 2, 1, 8, "lw_stall");
    run(6'b101011, 6'h00, 1'b0, 1, 0, 5, "sw_fstall");

    // Reset lands on a stalled store.
    bus1.op = 6'b101011; bus1.funct = '0; bus1.zero = 1'b0;
    m_fetch(0); m_decode(1'b0); m_memadr();
    begin
      obs_t o = base(5);
      o.iord = 1'b1; o.memwrite = 1'b1;
      add(o, 1'b0, 1'b1, 1'b1);
    end
    add(base(0), 1'b0, 1'b0, 1'b0);
    add(base(0), 1'b0, 1'b0, 1'b1);
    add(base(0), 1'b0, 1'b0, 1'b1);
    m_fetch(0); m_decode(1'b0); m_memadr(); m_memwr(0);
    play("rst_memwr");

    use2 = 1'b1;
    add(base(0), 1'b0, 1'b0, 1'b0);
    add(base(0), 1'b1, 1'b0, 1'b1);
    play("rst_both");
    run(6'b100011, 6'h00, 1'b0, 0, 0, 5, "lw_nowait");
    run(6'b000010, 6'h00, 1'b0, 0, 0, 3, "j_nowait");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
